// File: rtl/pc_table_pkg.sv
// Shared types for the programmable branch-target table: loader states,
// the stored entry layout and default table dimensions.
package pc_table_pkg;

  localparam int PC_TABLE_DEPTH_DEFAULT = 16;
  localparam int PC_TABLE_WIDTH_DEFAULT = 12;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2
  } pc_table_state_t;

  typedef struct packed {
    logic                              abs;
    logic [PC_TABLE_WIDTH_DEFAULT-1:0] val;
  } pc_entry_t;

endpackage

// File: rtl/pc_table_loader.sv
// Load sequencer for pc_target_table: tracks EMPTY/LOADING/ARMED, owns the
// write pointer and produces the registered load_done / armed flags.
module pc_table_loader
  import pc_table_pkg::*;
#(
  parameter int ENTRIES = PC_TABLE_DEPTH_DEFAULT,
  parameter int IW      = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_start,
  input  logic          i_load_valid,
  output logic          o_we,
  output logic [IW-1:0] o_wp,
  output logic          o_load_done,
  output logic          o_armed
);

  pc_table_state_t r_state;
  logic [IW-1:0]   r_wp;
  logic            r_load_done;
  logic            r_armed;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= EMPTY;
      r_wp        <= '0;
      r_load_done <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      if (i_load_start) begin
        // A restart drops armed on this edge so stale entries are never used.
        r_state <= LOADING;
        r_wp    <= '0;
        r_armed <= 1'b0;
      end else begin
        case (r_state)
          LOADING: begin
            if (i_load_valid) begin
              r_wp <= r_wp + IW'(1);
              if (r_wp == IW'(ENTRIES - 1)) begin
                r_state     <= ARMED;
                r_wp        <= '0;
                r_armed     <= 1'b1;
                r_load_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_we        = (r_state == LOADING) && i_load_valid && !i_load_start;
  assign o_wp        = r_wp;
  assign o_load_done = r_load_done;
  assign o_armed     = r_armed;

endmodule

// File: rtl/pc_target_table.sv
// Programmable branch-target table: combinational next-PC lookup over a
// streamed-in table. Define PC_TABLE_ABS_EN to store per-entry absolute flags.
module pc_target_table
  import pc_table_pkg::*;
#(
  parameter int D       = PC_TABLE_WIDTH_DEFAULT,
  parameter int A       = 6,
  parameter int ENTRIES = PC_TABLE_DEPTH_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load_start,
  input  logic         load_valid,
  input  logic [D:0]   load_data,
  output logic         load_done,
  output logic         armed,
  input  logic         br_en,
  input  logic [A-1:0] addr,
  input  logic [D-1:0] pc,
  output logic [D-1:0] next_pc,
  output logic         stall,
  output logic         bad_addr
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic          w_we;
  logic [IW-1:0] w_wp;
  logic          w_in_range;
  logic          w_bad_hit;
  pc_entry_t     w_entry;
  logic [D-1:0]  r_val [ENTRIES];
  logic          r_bad_addr;

  pc_table_loader #(.ENTRIES(ENTRIES), .IW(IW)) u_loader (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_load_start (load_start),
    .i_load_valid (load_valid),
    .o_we         (w_we),
    .o_wp         (w_wp),
    .o_load_done  (load_done),
    .o_armed      (armed)
  );

  // NOTE: the table is explicitly cleared on reset, so it maps to flops
  // rather than a RAM macro; a partial load must never leave stale entries.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) r_val[i] <= '0;
    end else if (w_we) begin
      r_val[w_wp] <= load_data[D-1:0];
    end
  end

`ifdef PC_TABLE_ABS_EN
  logic r_abs [ENTRIES];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) r_abs[i] <= 1'b0;
    end else if (w_we) begin
      r_abs[w_wp] <= load_data[D];
    end
  end

  assign w_entry.abs = r_abs[addr[IW-1:0]];
`else
  logic w_unused_abs;
  assign w_unused_abs = load_data[D];
  assign w_entry.abs  = 1'b0;
`endif

  assign w_entry.val = r_val[addr[IW-1:0]];
  assign w_in_range  = ({1'b0, addr} < (A + 1)'(ENTRIES));
  assign stall       = br_en && !armed;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_pc   = pc + D'(1);
    w_bad_hit = 1'b0;
    if (br_en) begin
      if (!armed) begin
        next_pc = pc;
      end else if (!w_in_range) begin
        next_pc   = pc;
        w_bad_hit = 1'b1;
      end else if (w_entry.abs) begin
        next_pc = w_entry.val;
      end else begin
        next_pc = pc + w_entry.val;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_bad_addr <= 1'b0;
    else if (w_bad_hit) r_bad_addr <= 1'b1;
  end

  assign bad_addr = r_bad_addr;

endmodule

// File: tb/tb_pc_target_table.sv
// Directed bench for pc_target_table: reset hold/stall, loading with gaps,
// wrap-around arithmetic, restart semantics, sticky bad_addr, abs mode.
module tb_pc_target_table;

  localparam int D       = 12;
  localparam int A       = 6;
  localparam int ENTRIES = 16;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         load_start = 1'b0;
  logic         load_valid = 1'b0;
  logic [D:0]   load_data = '0;
  logic         load_done;
  logic         armed;
  logic         br_en = 1'b0;
  logic [A-1:0] addr = '0;
  logic [D-1:0] pc = '0;
  logic [D-1:0] next_pc;
  logic         stall;
  logic         bad_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [D:0] tbl1 [ENTRIES];

  pc_target_table #(.D(D), .A(A), .ENTRIES(ENTRIES)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_done  (load_done),
    .armed      (armed),
    .br_en      (br_en),
    .addr       (addr),
    .pc         (pc),
    .next_pc    (next_pc),
    .stall      (stall),
    .bad_addr   (bad_addr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic lookup(input logic [A-1:0] a, input logic [D-1:0] p);
    br_en = 1'b1;
    addr  = a;
    pc    = p;
    #1;
  endtask

  task automatic load_word(input logic [D:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) tbl1[i] = {1'b0, 12'(i * 16)};
    tbl1[0] = {1'b0, 12'd11};
    tbl1[2] = {1'b0, 12'hFEF};   // -17
    tbl1[3] = {1'b1, 12'd200};

    // Reset state
    tick(); tick();
    Reset = 1'b0;
    check("rst_armed", 32'(armed), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_bad", 32'(bad_addr), 0);
    lookup(0, 12'd100);
    check("rst_hold_pc", 32'(next_pc), 100);
    check("rst_stall", 32'(stall), 1);
    br_en = 1'b0;
    #1;
    check("rst_incr_pc", 32'(next_pc), 101);
    check("rst_nostall", 32'(stall), 0);

    // Out-of-range lookup while not armed must not set bad_addr
    lookup(6'd20, 12'd5);
    tick();
    br_en = 1'b0;
    check("unarmed_oor_bad", 32'(bad_addr), 0);

    // First full load with gaps
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i % 5 == 2) tick();
      if (i == ENTRIES - 1) check("pre_final_armed", 32'(armed), 0);
      load_word(tbl1[i]);
    end
    check("load1_done_hi", 32'(load_done), 1);
    check("load1_armed", 32'(armed), 1);
    tick();
    check("load1_done_lo", 32'(load_done), 0);
    check("load1_armed_hold", 32'(armed), 1);

    lookup(2, 12'd40);
    check("neg_offset", 32'(next_pc), 23);
    check("armed_nostall", 32'(stall), 0);
    lookup(0, 12'd4090);
    check("wrap_branch", 32'(next_pc), 5);
    br_en = 1'b0;
    pc    = 12'd4095;
    #1;
    check("wrap_incr", 32'(next_pc), 0);
    lookup(3, 12'd50);
`ifdef PC_TABLE_ABS_EN
    check("abs_entry", 32'(next_pc), 200);
`else
    check("abs_ignored", 32'(next_pc), 250);
`endif
    lookup(5, 12'd100);
    check("entry5", 32'(next_pc), 180);
    br_en = 1'b0;

    // load_valid while armed without start is ignored
    load_word({1'b0, 12'h123});
    check("armed_valid_armed", 32'(armed), 1);
    check("armed_valid_done", 32'(load_done), 0);
    lookup(0, 12'd4090);
    check("armed_valid_nowrite", 32'(next_pc), 5);
    br_en = 1'b0;

    // Partial reload, then restart with a dropped valid, then full load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("reload_armed_drop", 32'(armed), 0);
    lookup(2, 12'd40);
    check("reload_hold", 32'(next_pc), 40);
    check("reload_stall", 32'(stall), 1);
    br_en = 1'b0;
    for (int i = 0; i < 5; i++) load_word(13'(50 + i));
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 13'h555;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    for (int i = 0; i < ENTRIES; i++) load_word(13'(300 + 3 * i));
    check("load2_done_hi", 32'(load_done), 1);
    check("load2_armed", 32'(armed), 1);
    for (int i = 0; i < 5; i++) begin
      lookup(6'(i), 12'd1000);
      check($sformatf("reload_entry%0d", i), 32'(next_pc), 32'(1300 + 3 * i));
    end
    lookup(15, 12'd0);
    check("last_entry", 32'(next_pc), 345);

    // Out-of-range lookups and sticky bad_addr
    lookup(16, 12'd300);
    check("oor16_hold", 32'(next_pc), 300);
    check("oor16_nostall", 32'(stall), 0);
    check("oor16_bad_pre", 32'(bad_addr), 0);
    tick();
    check("oor16_bad_set", 32'(bad_addr), 1);
    lookup(1, 12'd10);
    check("valid_after_bad", 32'(next_pc), 313);
    tick();
    check("bad_sticky", 32'(bad_addr), 1);
    lookup(20, 12'd77);
    check("oor20_hold", 32'(next_pc), 77);
    br_en = 1'b0;

    // Reset clears everything
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst2_bad", 32'(bad_addr), 0);
    check("rst2_armed", 32'(armed), 0);
    check("rst2_done", 32'(load_done), 0);
    lookup(0, 12'd100);
    check("rst2_hold", 32'(next_pc), 100);
    check("rst2_stall", 32'(stall), 1);
    br_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_target_table.md
# pc_target_table

Programmable branch-target table for the fetch stage, replacing the fixed compile-time PC lookup. It holds `ENTRIES` signed offsets (optionally absolute targets) that a loader streams in after reset. The fetch stage presents a branch index; the block returns the next PC directly. Until a load completes, the block holds the PC and asserts a stall.

## Interface
- `D`, 12, PC width in bits; offsets are D-bit two's complement.
- `A`, 6, index width of `addr`.
- `ENTRIES`, 16, table depth; `ENTRIES <= 2**A`.
- `Clk`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle pulse that begins or restarts a table load.
- `load_valid`  in  1  `load_data` carries the next entry this cycle.
- `load_data`  in  D+1  bits [D-1:0] are the offset or target; bit D is the absolute flag.
- `load_done`  out  1  one-cycle pulse after the final entry is written.
- `armed`  out  1  table is loaded and lookups are live.
- `br_en`  in  1  a branch is taken this cycle.
- `addr`  in  A  table index.
- `pc`  in  D  current PC.
- `next_pc`  out  D  combinational next PC.
- `stall`  out  1  combinational; `br_en` while not armed.
- `bad_addr`  out  1  sticky flag: an out-of-range index was used while armed.

## Operation
- Three states:
  - EMPTY: reset state, never loaded.
  - LOADING: loader is writing entries.
  - ARMED: table is live.
- Reset drives the state to EMPTY, the write pointer `wp` to 0, and every entry to 0 (abs flag 0). It also clears `load_done`, `armed` and `bad_addr`.
- `load_start` in any state: go to LOADING with `wp=0`. Any `load_valid` in the same cycle is dropped; start wins.
- LOADING with `load_valid`: write `entry[wp] <= load_data`, then `wp++`.
  - On the write where `wp == ENTRIES-1`: go to ARMED and pulse `load_done` the next cycle.
  - No timeout; `load_valid` gaps are allowed.
- `load_valid` in EMPTY or ARMED without `load_start` is ignored.
- A reload from ARMED drops `armed` immediately, so old contents are never used during a partial reload.
- `next_pc`:
  - Not `br_en`: `pc+1`.
  - `br_en` and not armed: `pc` (hold), with `stall=1`.
  - `br_en`, armed, `addr >= ENTRIES`: `pc` (hold); `bad_addr` sets the next cycle.
  - `br_en`, armed, entry relative: `pc + offset`.
  - `br_en`, armed, entry absolute: `target`.
- All arithmetic is modulo 2^D; wrap-around is silent.
- Lookup reads pre-edge contents. A write and a read of the same entry in the same cycle returns the old value.
- `bad_addr` clears only on `Reset`.

## Timing
- `next_pc` and `stall` are purely combinational from `br_en`, `addr`, `pc` and the registered state/table, so lookup latency is 0 cycles.
- `armed` rises the cycle after the final write. `load_done` is high for exactly that same one cycle.
- Loading a full table takes at least `ENTRIES` cycles after `load_start`. The minimum start-to-`armed` time is `ENTRIES+1` edges.
- `Reset` mid-load returns to EMPTY on that edge; partially written entries are cleared.

## Configuration
- `PC_TABLE_ABS_EN` defined: bit D of each entry is stored and selects absolute mode.
- `PC_TABLE_ABS_EN` undefined:
  - The flag bit is not stored, and every entry is relative.
  - `load_data[D]` is ignored; port width is unchanged.

## Structure
- A shared package `pc_table_pkg` holds:
  - The state enum (`EMPTY`, `LOADING`, `ARMED`).
  - The entry struct `{abs, val[D-1:0]}`.
  - The `PC_TABLE_DEPTH_DEFAULT` constant.
- Sub-module `pc_table_loader` contains the FSM, the write pointer, `load_done` and `armed`. It drives write-enable and write-index into the storage and next-PC logic in the top.

## Test plan
- Reset, then `br_en=1`, `addr=0`, `pc=100` → `next_pc=100`, `stall=1`, `armed=0`.
- Load 16 entries with entry 2 = −17 and `load_valid` gaps. Then `br_en`, `addr=2`, `pc=40` → `next_pc=23`; `load_done` is high for one cycle only.
- Armed, `pc=4090`, entry 0 = +11 (D=12) → `next_pc=5` (wrap). `br_en=0`, `pc=4095` → `next_pc=0`.
- `load_start` after 5 writes, then a full load → entries 0–4 hold the new data. `load_start` together with `load_valid` → that data is dropped.
- Armed, `addr=20` → `next_pc=pc`; `bad_addr` stays 1 after further valid lookups until `Reset`.
- With `PC_TABLE_ABS_EN`: entry 3 = {1, 200}, `pc=50` → `next_pc=200`. Without the macro, the same load gives `next_pc=250`.
